// File: rtl/serial_rx_param_pkg.sv
// Shared definitions for the parametrised serial receiver.
//   - parity mode codes (PARITY parameter values)
//   - receive FSM state encoding
//   - small helpers: 3-input majority vote, parity mismatch decision
package serial_rx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ones_odd is the XOR over data bits and the received parity bit.
  function automatic logic parity_mismatch(input int mode, input logic ones_odd);
    logic err;
    case (mode)
      PAR_ODD:  err = ~ones_odd;
      PAR_EVEN: err = ones_odd;
      PAR_NONE: err = 1'b0;
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/serial_rx_param_bit_sampler.sv
// Line front end for the serial receiver: 2-flop synchroniser, falling-edge
// detect, free-running bit-period timer and 3-sample majority vote.
// Ports:
//   clk, rst    clock, async active-high reset
//   rx          raw serial line (asynchronous)
//   restart     realign the bit timer to a start edge seen this cycle
//   rx_sync     synchronised line level
//   fall_edge   synchronised line went 1 -> 0 this cycle
//   bit_strobe  one-cycle pulse at the third sample point of a bit
//   bit_val     majority of the three samples (valid with bit_strobe)
module serial_rx_param_bit_sampler
  import serial_rx_param_pkg::*;
#(
  parameter int CLK_PER_BIT = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rx_sync,
  output logic fall_edge,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int CW = $clog2(CLK_PER_BIT);

  // Down-counter; elapsed clocks into the bit = CLK_PER_BIT-1-cnt.
  // The edge cycle itself is elapsed 0, so restart loads elapsed 1.
  localparam logic [CW-1:0] CNT_RELOAD  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_RESTART = CW'(CLK_PER_BIT - 2);
  localparam logic [CW-1:0] CNT_S0      = CW'(CLK_PER_BIT - CLK_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_S1      = CW'(CLK_PER_BIT - 1 - CLK_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_S2      = CW'(CLK_PER_BIT - 2 - CLK_PER_BIT / 2);

  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          samp_a_q, samp_a_d;
  logic          samp_b_q, samp_b_d;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;

    if (restart)          cnt_d = CNT_RESTART;
    else if (cnt_q == '0) cnt_d = CNT_RELOAD;
    else                  cnt_d = cnt_q - 1'b1;

    if (cnt_q == CNT_S0) samp_a_d = rx_sync_q;
    if (cnt_q == CNT_S1) samp_b_d = rx_sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= CNT_RELOAD;
      samp_a_q  <= 1'b1;
      samp_b_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
    end
  end

  assign rx_sync    = rx_sync_q;
  assign fall_edge  = rx_prev_q & ~rx_sync_q;
  // Third sample is taken live so the decision lands on the third sample cycle.
  assign bit_strobe = (cnt_q == CNT_S2);
  assign bit_val    = majority3(samp_a_q, samp_b_q, rx_sync_q);

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised asynchronous serial receiver with majority-vote sampling,
// optional parity, 1 or 2 stop bits, error flags and a valid/ready output.
// Ports:
//   clk, rst     clock, async active-high reset
//   rx           serial line, idle high
//   data         received word (holding register)
//   valid/ready  output handshake; word accepted when both high
//   parity_err   parity mismatch on held word
//   frame_err    a stop bit sampled 0 on held word
//   overrun      a frame was dropped while the held word waited; sticky
//   busy         receiver is inside a frame
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for an armed start edge
// ST_START  | checking the start bit at mid-bit (1 = false start)
// ST_DATA   | shifting data bits in, LSB first
// ST_PARITY | capturing the parity bit (only when PARITY != 0)
// ST_STOP   | checking stop bit(s); commit on the last one
module serial_rx_param
  import serial_rx_param_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] ARM_LOAD = CW'(CLK_PER_BIT - 1);

  logic rx_sync, fall_edge, bit_strobe, bit_val;
  logic restart;

  serial_rx_param_bit_sampler #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .restart   (restart),
    .rx_sync   (rx_sync),
    .fall_edge (fall_edge),
    .bit_strobe(bit_strobe),
    .bit_val   (bit_val)
  );

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 par_bit_q, par_bit_d;
  logic                 armed_q, armed_d;
  logic [CW-1:0]        arm_cnt_q, arm_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic commit;
  logic frame_bad;
  logic perr_new;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    stop_cnt_d   = stop_cnt_q;
    ferr_acc_d   = ferr_acc_q;
    par_bit_d    = par_bit_q;
    armed_d      = armed_q;
    arm_cnt_d    = arm_cnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    restart      = 1'b0;
    commit       = 1'b0;
    frame_bad    = ferr_acc_q | ~bit_val;
    perr_new     = parity_mismatch(PARITY, ^{shift_q, par_bit_q});

    case (state_q)
      ST_IDLE: begin
        if (armed_q && fall_edge) begin
          state_d    = ST_START;
          restart    = 1'b1;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          ferr_acc_d = 1'b0;
          par_bit_d  = 1'b0;
        end
      end
      ST_START: begin
        if (bit_strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_strobe) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BW'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_strobe) begin
          par_bit_d = bit_val;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_strobe) begin
          if (!bit_val) ferr_acc_d = 1'b1;
          // Commit mid-stop so a back-to-back start edge is not missed.
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A framing error (e.g. a break) requires a full bit of idle line
    // before the next start edge is trusted.
    if (commit && frame_bad) begin
      armed_d   = 1'b0;
      arm_cnt_d = ARM_LOAD;
    end else if (!armed_q) begin
      if (!rx_sync)               arm_cnt_d = ARM_LOAD;
      else if (arm_cnt_q == '0)   armed_d   = 1'b1;
      else                        arm_cnt_d = arm_cnt_q - 1'b1;
    end

    if (commit) begin
      if (!valid_q || ready) begin
        data_d       = shift_q;
        parity_err_d = perr_new;
        frame_err_d  = frame_bad;
        valid_d      = 1'b1;
        overrun_d    = 1'b0;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d      = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      par_bit_q    <= 1'b0;
      armed_q      <= 1'b0;
      arm_cnt_q    <= ARM_LOAD;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      ferr_acc_q   <= ferr_acc_d;
      par_bit_q    <= par_bit_d;
      armed_q      <= armed_d;
      arm_cnt_q    <= arm_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
